// File: rtl/hook_pkg.sv
// hook_pkg: shared types and default constants for the fishing-hook controller.
//   hook_state_e : controller states (idle / dropping / waiting at bottom / reeling in)
//   POS_W        : width of the h/v position buses, in tenths of a pixel
//   *_DEF        : default geometry, motion steps and timing used by hook_ctrl and hook_sway
package hook_pkg;

  localparam int unsigned POS_W = 14;

  localparam int unsigned V_TOP_DEF            = 720;
  localparam int unsigned V_BOTTOM_DEF         = 4700;
  localparam int unsigned H_HOME_DEF           = 2580;
  localparam int unsigned DROP_STEP_DEF        = 20;
  localparam int unsigned REEL_STEP_DEF        = 30;
  localparam int unsigned REEL_STEP_HOOKED_DEF = 15;
  localparam int unsigned WAIT_TICKS_DEF       = 120;
  localparam int unsigned SWAY_STEP_DEF        = 5;
  localparam int unsigned SWAY_AMP_DEF         = 60;

  typedef enum logic [1:0] {
    StIdle,
    StDrop,
    StWait,
    StReel
  } hook_state_e;

endpackage

// File: rtl/hook_ctrl_if.sv
// hook_ctrl_if: control/status bundle between the game logic and hook_ctrl.
//   tick, cast, reel, caught : one-cycle pulses into the controller
//   h_position, v_position   : hook position in tenths of a pixel
//   hooked, landed, busy     : controller status
// Modports: master drives the pulses (game side), slave is the controller.
interface hook_ctrl_if;

  logic                       tick;
  logic                       cast;
  logic                       reel;
  logic                       caught;
  logic [hook_pkg::POS_W-1:0] h_position;
  logic [hook_pkg::POS_W-1:0] v_position;
  logic                       hooked;
  logic                       landed;
  logic                       busy;

  modport master (
    output tick, cast, reel, caught,
    input  h_position, v_position, hooked, landed, busy
  );

  modport slave (
    input  tick, cast, reel, caught,
    output h_position, v_position, hooked, landed, busy
  );

endinterface

// File: rtl/hook_sway.sv
// hook_sway: horizontal triangle-wave sway of the hook while it is out of the boat.
// Only instantiated when HOOK_SWAY_EN is defined.
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : motion strobe (already gated against control-event cycles)
//   enable     : low snaps the hook back to home and restarts the rising phase
//   home       : centre column
//   h_position : current column
module hook_sway
  import hook_pkg::*;
#(
  parameter int unsigned SWAY_STEP = SWAY_STEP_DEF,
  parameter int unsigned SWAY_AMP  = SWAY_AMP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             enable,
  input  logic [POS_W-1:0] home,
  output logic [POS_W-1:0] h_position
);

  localparam logic signed [POS_W:0] Step = (POS_W + 1)'(SWAY_STEP);
  localparam logic signed [POS_W:0] Amp  = (POS_W + 1)'(SWAY_AMP);

  // Offset from home is kept instead of the absolute column so reset is a constant.
  logic signed [POS_W:0] off_q, off_d;
  logic                  falling_q, falling_d;
  logic signed [POS_W:0] h_full;

  always_comb begin
    off_d     = off_q;
    falling_d = falling_q;
    if (!enable) begin
      off_d     = '0;
      falling_d = 1'b0;
    end else if (tick) begin
      if (!falling_q) begin
        if (off_q + Step >= Amp) begin
          off_d     = Amp;
          falling_d = 1'b1;
        end else begin
          off_d = off_q + Step;
        end
      end else begin
        if (off_q - Step <= -Amp) begin
          off_d     = -Amp;
          falling_d = 1'b0;
        end else begin
          off_d = off_q - Step;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q     <= '0;
      falling_q <= 1'b0;
    end else begin
      off_q     <= off_d;
      falling_q <= falling_d;
    end
  end

  always_comb begin
    h_full     = $signed({1'b0, home}) + off_q;
    h_position = h_full[POS_W-1:0];
  end

endmodule

// File: rtl/hook_ctrl.sv
// hook_ctrl: fishing-hook state machine. Drops the hook on cast, waits at the bottom,
// reels back in on request, on a catch or after a timeout, and pulses landed when a
// hooked fish reaches the surface row. All motion happens on tick cycles only.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : hook_ctrl_if.slave (tick/cast/reel/caught in; positions and status out)
// Optional feature: define HOOK_SWAY_EN to sway the hook horizontally via hook_sway;
// otherwise h_position is the constant H_HOME.
module hook_ctrl
  import hook_pkg::*;
#(
  parameter int unsigned V_TOP            = V_TOP_DEF,
  parameter int unsigned V_BOTTOM         = V_BOTTOM_DEF,
  parameter int unsigned H_HOME           = H_HOME_DEF,
  parameter int unsigned DROP_STEP        = DROP_STEP_DEF,
  parameter int unsigned REEL_STEP        = REEL_STEP_DEF,
  parameter int unsigned REEL_STEP_HOOKED = REEL_STEP_HOOKED_DEF,
  parameter int unsigned WAIT_TICKS       = WAIT_TICKS_DEF
) (
  input logic        clk,
  input logic        rst_n,
  hook_ctrl_if.slave bus
);

  localparam logic [POS_W:0]   VTop           = (POS_W + 1)'(V_TOP);
  localparam logic [POS_W:0]   VBottom        = (POS_W + 1)'(V_BOTTOM);
  localparam logic [POS_W:0]   DropStep       = (POS_W + 1)'(DROP_STEP);
  localparam logic [POS_W:0]   ReelStep       = (POS_W + 1)'(REEL_STEP);
  localparam logic [POS_W:0]   ReelStepHooked = (POS_W + 1)'(REEL_STEP_HOOKED);
  localparam logic [POS_W-1:0] HHome          = POS_W'(H_HOME);
  localparam logic [7:0]       WaitTicks      = 8'(WAIT_TICKS);

  hook_state_e      state_q, state_d;
  logic [POS_W-1:0] v_q, v_d;
  logic             hooked_q, hooked_d;
  logic             landed_q, landed_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [POS_W:0]   drop_sum;
  logic [POS_W:0]   reel_step;

  always_comb begin
    state_d    = state_q;
    v_d        = v_q;
    hooked_d   = hooked_q;
    landed_d   = 1'b0;
    wait_cnt_d = wait_cnt_q;
    drop_sum   = {1'b0, v_q} + DropStep;
    reel_step  = hooked_q ? ReelStepHooked : ReelStep;

    unique case (state_q)
      StIdle: begin
        if (bus.cast) begin
          state_d = StDrop;
        end
      end
      StDrop, StWait: begin
        // Control events win over tick: state changes, the hook does not move.
        if (bus.caught || bus.reel) begin
          state_d  = StReel;
          hooked_d = hooked_q | bus.caught;
        end else if (bus.tick) begin
          if (state_q == StDrop) begin
            if (drop_sum >= VBottom) begin
              v_d        = VBottom[POS_W-1:0];
              state_d    = StWait;
              wait_cnt_d = '0;
            end else begin
              v_d = drop_sum[POS_W-1:0];
            end
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
            if (wait_cnt_d == WaitTicks) begin
              state_d = StReel;
            end
          end
        end
      end
      StReel: begin
        if (bus.tick) begin
          // Compare before subtracting so a step larger than v cannot wrap.
          if ({1'b0, v_q} <= VTop + reel_step) begin
            v_d      = VTop[POS_W-1:0];
            state_d  = StIdle;
            landed_d = hooked_q;
            hooked_d = 1'b0;
          end else begin
            v_d = v_q - reel_step[POS_W-1:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      v_q        <= VTop[POS_W-1:0];
      hooked_q   <= 1'b0;
      landed_q   <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      v_q        <= v_d;
      hooked_q   <= hooked_d;
      landed_q   <= landed_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign bus.v_position = v_q;
  assign bus.hooked     = hooked_q;
  assign bus.landed     = landed_q;
  assign bus.busy       = (state_q != StIdle);

`ifdef HOOK_SWAY_EN
  logic sway_tick;
  logic sway_en;

  // No sway on edges where a control event changes state.
  assign sway_tick = bus.tick && (state_q != StIdle) &&
                     !(((state_q == StDrop) || (state_q == StWait)) && (bus.caught || bus.reel));
  // Uses next state so the hook is back at home on the edge that enters idle.
  assign sway_en   = (state_d != StIdle);

  hook_sway #(
    .SWAY_STEP (SWAY_STEP_DEF),
    .SWAY_AMP  (SWAY_AMP_DEF)
  ) u_sway (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (sway_tick),
    .enable     (sway_en),
    .home       (HHome),
    .h_position (bus.h_position)
  );
`else
  assign bus.h_position = HHome;
`endif

endmodule

// File: tb/tb_hook_ctrl.sv
// tb_hook_ctrl: directed stimulus for hook_ctrl. Each stimulus cycle queues the outputs
// expected after the next rising edge; a monitor pops and compares one entry per edge.
module tb_hook_ctrl;
  import hook_pkg::*;

  typedef struct {
    string tag;
    int    v;
    int    busy;
    int    hooked;
    int    landed;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  hook_ctrl_if bus_if ();

  hook_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void cmp(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  function automatic exp_t mk(input string tag, input int v, input int b, input int h,
                              input int l);
    exp_t e;
    e.tag = tag; e.v = v; e.busy = b; e.hooked = h; e.landed = l;
    return e;
  endfunction

  function automatic void check_outs(input exp_t e);
    cmp({e.tag, " v_position"}, int'(bus_if.v_position), e.v);
    cmp({e.tag, " busy"}, int'(bus_if.busy), e.busy);
    cmp({e.tag, " hooked"}, int'(bus_if.hooked), e.hooked);
    cmp({e.tag, " landed"}, int'(bus_if.landed), e.landed);
`ifndef HOOK_SWAY_EN
    cmp({e.tag, " h_position"}, int'(bus_if.h_position), 2580);
`endif
  endfunction

  // Monitor: one expectation per rising edge, sampled 1 time unit after it.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) check_outs(exp_q.pop_front());
  end

  task automatic cyc(input logic t, input logic c, input logic r, input logic k,
                     input int ev, input int eb, input int eh, input int el,
                     input string tag);
    @(negedge clk);
    bus_if.tick   = t;
    bus_if.cast   = c;
    bus_if.reel   = r;
    bus_if.caught = k;
    exp_q.push_back(mk(tag, ev, eb, eh, el));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.tick   = 1'b0;
    bus_if.cast   = 1'b0;
    bus_if.reel   = 1'b0;
    bus_if.caught = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_outs(mk("reset", 720, 0, 0, 0));
    @(negedge clk) rst_n = 1'b1;

    cyc(0, 0, 0, 0, 720, 0, 0, 0, "idle");
    cyc(1, 0, 1, 1, 720, 0, 0, 0, "idle ignores reel/caught");

    // Full drop to the bottom, timeout in WAIT, unhooked reel back to the top.
    cyc(1, 1, 0, 0, 720, 1, 0, 0, "cast with tick no motion");
    cyc(0, 0, 0, 0, 720, 1, 0, 0, "drop without tick");
    for (int k = 1; k <= 199; k++) cyc(1, 0, 0, 0, 720 + 20 * k, 1, 0, 0, "drop");
    cyc(0, 1, 0, 0, 4700, 1, 0, 0, "wait ignores cast");
    for (int k = 1; k <= 120; k++) cyc(1, 0, 0, 0, 4700, 1, 0, 0, "wait");
    for (int k = 1; k <= 133; k++)
      cyc(1, 0, 0, 0, (k == 133) ? 720 : 4700 - 30 * k, (k < 133) ? 1 : 0, 0, 0, "auto reel");
    cyc(0, 0, 0, 0, 720, 0, 0, 0, "idle after empty reel");

    // Catch at v=920 (coinciding with tick), hooked reel, single landed pulse.
    cyc(0, 1, 0, 0, 720, 1, 0, 0, "cast2");
    for (int k = 1; k <= 10; k++) cyc(1, 0, 0, 0, 720 + 20 * k, 1, 0, 0, "drop2");
    cyc(1, 0, 0, 1, 920, 1, 1, 0, "caught with tick");
    for (int k = 1; k <= 14; k++)
      cyc(1, 0, 0, 0, (k == 14) ? 720 : 920 - 15 * k, (k < 14) ? 1 : 0, (k < 14) ? 1 : 0,
          (k == 14) ? 1 : 0, "hooked reel");
    cyc(1, 0, 0, 0, 720, 0, 0, 0, "landed single cycle");

    // caught and reel together, then cast while reeling.
    cyc(0, 1, 0, 0, 720, 1, 0, 0, "cast3");
    for (int k = 1; k <= 5; k++) cyc(1, 0, 0, 0, 720 + 20 * k, 1, 0, 0, "drop3");
    cyc(0, 0, 1, 1, 820, 1, 1, 0, "caught+reel");
    cyc(1, 1, 0, 0, 805, 1, 1, 0, "cast in reel ignored");
    for (int k = 2; k <= 7; k++)
      cyc(1, 0, 0, 0, (k == 7) ? 720 : 820 - 15 * k, (k < 7) ? 1 : 0, (k < 7) ? 1 : 0,
          (k == 7) ? 1 : 0, "reel3");
    cyc(0, 0, 0, 0, 720, 0, 0, 0, "idle after land3");

    // reel with tick in DROP, then a step landing exactly on the top row.
    cyc(0, 1, 0, 0, 720, 1, 0, 0, "cast4");
    for (int k = 1; k <= 3; k++) cyc(1, 0, 0, 0, 720 + 20 * k, 1, 0, 0, "drop4");
    cyc(1, 0, 1, 0, 780, 1, 0, 0, "reel with tick no motion");
    cyc(1, 0, 0, 0, 750, 1, 0, 0, "reel4");
    cyc(1, 0, 0, 0, 720, 0, 0, 0, "reel exact top");
    cyc(0, 0, 0, 0, 720, 0, 0, 0, "no landed when empty");

    // Asynchronous reset while reeling a hooked fish at v=2000.
    cyc(0, 1, 0, 0, 720, 1, 0, 0, "cast5");
    for (int k = 1; k <= 64; k++) cyc(1, 0, 0, 0, 720 + 20 * k, 1, 0, 0, "drop5");
    cyc(0, 0, 0, 1, 2000, 1, 1, 0, "hooked at 2000");
    @(negedge clk);
    bus_if.caught = 1'b0;
    bus_if.tick   = 1'b1;
    exp_q.push_back(mk("reel5", 1985, 1, 1, 0));
    @(negedge clk);
    bus_if.tick = 1'b0;
    exp_q.push_back(mk("reel5 hold", 1985, 1, 1, 0));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_outs(mk("async reset", 720, 0, 0, 0));
    @(posedge clk);
    #1 check_outs(mk("held in reset", 720, 0, 0, 0));
    @(negedge clk) rst_n = 1'b1;
    cyc(1, 0, 0, 0, 720, 0, 0, 0, "after reset 1");
    cyc(1, 0, 0, 0, 720, 0, 0, 0, "after reset 2");
    @(negedge clk);
    bus_if.tick = 1'b0;

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    cmp("scoreboard drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
